// File: rtl/input_editor_pkg.sv
// Shared types and helpers for the input editor.
// Mode codes, digit geometry, button indices and BCD stepping.
package input_editor_pkg;

  localparam int DIG_W = 5;
  localparam int N_DIG = 4;

  localparam int BTN_RIGHT = 0;
  localparam int BTN_INC   = 1;
  localparam int BTN_DEC   = 2;
  localparam int BTN_LEFT  = 3;

  localparam logic [DIG_W-1:0] BCD_MAX = DIG_W'(9);

  typedef enum logic [3:0] {
    MODE_OFF = 4'd0,
    MODE_DEC = 4'd1,
    MODE_HEX = 4'd2,
    MODE_OCT = 4'd3,
    MODE_BIN = 4'd4,
    MODE_BCD = 4'd5
  } mode_e;

  typedef logic [N_DIG-1:0][DIG_W-1:0] digits_t;

  typedef struct packed {
    logic    ovf;
    digits_t dig;
  } bcd_res_t;

  function automatic logic mode_ok(logic [3:0] m);
    return (m >= 4'd1) && (m <= 4'd5);
  endfunction

  function automatic logic [DIG_W-1:0] mode_max(logic [3:0] m);
    logic [DIG_W-1:0] r;
    case (m)
      MODE_DEC: r = DIG_W'(9);
      MODE_HEX: r = DIG_W'(15);
      MODE_OCT: r = DIG_W'(7);
      MODE_BIN: r = DIG_W'(1);
      MODE_BCD: r = DIG_W'(9);
      default:  r = '0;
    endcase
    return r;
  endfunction

  // Ripple +/-1 from digit pos upward; ovf set when carry leaves digit 3.
  function automatic bcd_res_t bcd_step(digits_t d, logic [1:0] pos,
                                        logic dn);
    bcd_res_t r;
    logic     cy;
    r.dig = d;
    cy    = 1'b1;
    for (int i = 0; i < N_DIG; i++) begin
      if (i >= int'(pos) && cy) begin
        if (dn) begin
          if (d[i] == '0) begin
            r.dig[i] = BCD_MAX;
          end else begin
            r.dig[i] = d[i] - DIG_W'(1);
            cy       = 1'b0;
          end
        end else begin
          if (d[i] >= BCD_MAX) begin
            r.dig[i] = '0;
          end else begin
            r.dig[i] = d[i] + DIG_W'(1);
            cy       = 1'b0;
          end
        end
      end
    end
    r.ovf = cy;
    return r;
  endfunction

endpackage

// File: rtl/input_editor_debounce.sv
// Debouncer: 2-FF synchronizer plus stability counter.
// Emits the debounced level and a one-cycle rising-edge pulse.
module debounce
  import input_editor_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1_q, s2_q;
  logic          lvl_q, lvl_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Count while the synced sample differs from the level; restart otherwise.
  always_comb begin
    cnt_d  = '0;
    lvl_d  = lvl_q;
    rise_d = 1'b0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        lvl_d  = s2_q;
        rise_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Synchronizer, counter and level registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= raw;
      s2_q   <= s1_q;
      lvl_q  <= lvl_d;
      rise_q <= rise_d;
      cnt_q  <= cnt_d;
    end
  end

  assign level      = lvl_q;
  assign rise_pulse = rise_q;

endmodule

// File: rtl/input_editor.sv
// Button front-end and 4-digit editor with cursor.
// Mode selects digit radix; mode 5 is carrying BCD.
module input_editor
  import input_editor_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  btn_raw,
  input  logic        clr_raw,
  input  logic [3:0]  mode,
  output logic [2:0]  curr,
  output logic [19:0] nout,
  output logic        p,
  output logic        error
);

  logic [3:0] btn_lvl, btn_pul;
  logic       clr_lvl, clr_pul;
  logic       unused_db;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk        (clk),
      .rst        (rst),
      .raw        (btn_raw[i]),
      .level      (btn_lvl[i]),
      .rise_pulse (btn_pul[i])
    );
  end

  debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
    .clk        (clk),
    .rst        (rst),
    .raw        (clr_raw),
    .level      (clr_lvl),
    .rise_pulse (clr_pul)
  );

  assign unused_db = ^{btn_lvl, clr_pul};

  digits_t          dig_q, dig_d;
  logic [1:0]       curr_q, curr_d;
  logic             p_q, p_d;
  logic             err_q, err_d;
  logic [3:0]       mode_q;
  logic             act, mchg;
  logic [DIG_W-1:0] cd, mx;
  bcd_res_t         bres;

  assign act  = mode_ok(mode);
  assign mchg = act && mode_ok(mode_q) && (mode != mode_q);
  assign cd   = dig_q[curr_q];
  assign mx   = mode_max(mode);
  assign bres = bcd_step(dig_q, curr_q, ~btn_pul[BTN_INC]);

  // One action per cycle: clear > left > right > inc > dec.
  always_comb begin
    dig_d  = dig_q;
    curr_d = curr_q;
    p_d    = p_q;
    err_d  = err_q;
    if (clr_lvl || mchg) begin
      dig_d  = '0;
      curr_d = '0;
      p_d    = 1'b0;
      err_d  = 1'b0;
    end else if (act) begin
      if (btn_pul[BTN_LEFT]) begin
        curr_d = curr_q + 2'd1;
      end else if (btn_pul[BTN_RIGHT]) begin
        curr_d = curr_q - 2'd1;
      end else if (btn_pul[BTN_INC] || btn_pul[BTN_DEC]) begin
        p_d = 1'b1;
        if (mode == MODE_BCD) begin
          if (bres.ovf) err_d = 1'b1;
          else          dig_d = bres.dig;
        end else if (btn_pul[BTN_INC]) begin
          if (cd < mx) dig_d[curr_q] = cd + DIG_W'(1);
          else         err_d = 1'b1;
        end else begin
          if (cd != '0) dig_d[curr_q] = cd - DIG_W'(1);
          else          err_d = 1'b1;
        end
      end
    end
  end

  // Editor state and previous-mode tracking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig_q  <= '0;
      curr_q <= '0;
      p_q    <= 1'b0;
      err_q  <= 1'b0;
      mode_q <= '0;
    end else begin
      dig_q  <= dig_d;
      curr_q <= curr_d;
      p_q    <= p_d;
      err_q  <= err_d;
      mode_q <= mode;
    end
  end

  assign nout  = dig_q;
  assign curr  = {1'b0, curr_q};
  assign p     = p_q;
  assign error = err_q;

endmodule

// File: tb/tb_input_editor.sv
// Bench for input_editor with an abstract digit/cursor model.
// Directed presses, mode changes and clear with literal pins.
module tb_input_editor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  btn_raw = '0;
  logic        clr_raw = 1'b0;
  logic [3:0]  mode = '0;
  logic [2:0]  curr;
  logic [19:0] nout;
  logic        p, error;

  always #5 clk = ~clk;

  input_editor #(.DB_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst_n),
    .btn_raw (btn_raw),
    .clr_raw (clr_raw),
    .mode    (mode),
    .curr    (curr),
    .nout    (nout),
    .p       (p),
    .error   (error)
  );

  int ntests = 0;
  int nfail  = 0;
  bit settled = 1'b0;

  int md[4];
  int mcur;
  bit mp, merr;

  function automatic bit in_range(int m);
    return m >= 1 && m <= 5;
  endfunction

  function automatic logic [19:0] exp_nout();
    logic [19:0] e;
    for (int i = 0; i < 4; i++) e[i*5 +: 5] = md[i][4:0];
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) md[i] = 0;
    mcur = 0;
    mp   = 1'b0;
    merr = 1'b0;
  endtask

  task automatic model_apply(logic [3:0] mask);
    int m, mx, val, nv, pw;
    m = int'(mode);
    if (!in_range(m)) return;
    if (mask[3]) begin
      mcur = (mcur + 1) % 4;
    end else if (mask[0]) begin
      mcur = (mcur + 3) % 4;
    end else if (mask[1] || mask[2]) begin
      mp = 1'b1;
      if (m == 5) begin
        val = md[3]*1000 + md[2]*100 + md[1]*10 + md[0];
        pw = 1;
        for (int k = 0; k < mcur; k++) pw *= 10;
        nv = mask[1] ? val + pw : val - pw;
        if (nv < 0 || nv > 9999) begin
          merr = 1'b1;
        end else begin
          md[0] = nv % 10;
          md[1] = (nv / 10) % 10;
          md[2] = (nv / 100) % 10;
          md[3] = nv / 1000;
        end
      end else begin
        mx = (m == 1) ? 9 : (m == 2) ? 15 : (m == 3) ? 7 : 1;
        if (mask[1]) begin
          if (md[mcur] < mx) md[mcur]++;
          else merr = 1'b1;
        end else begin
          if (md[mcur] > 0) md[mcur]--;
          else merr = 1'b1;
        end
      end
    end
  endtask

  // Cycle-by-cycle comparison against the model whenever it is settled.
  always @(negedge clk) begin
    if (settled && rst_n) begin
      check("nout", nout, exp_nout());
      check("curr", curr, mcur);
      check("p", p, mp);
      check("error", error, merr);
    end
  end

  task automatic press(logic [3:0] mask);
    settled = 1'b0;
    @(posedge clk); #1 btn_raw = mask;
    repeat (10) @(posedge clk);
    #1 btn_raw = '0;
    repeat (10) @(posedge clk);
    model_apply(mask);
    #1 settled = 1'b1;
  endtask

  task automatic set_mode(logic [3:0] m);
    settled = 1'b0;
    @(posedge clk); #1;
    if (in_range(int'(mode)) && in_range(int'(m)) && mode != m)
      model_clear();
    mode = m;
    repeat (3) @(posedge clk);
    #1 settled = 1'b1;
  endtask

  task automatic pulse_clr();
    settled = 1'b0;
    @(posedge clk); #1 clr_raw = 1'b1;
    repeat (10) @(posedge clk);
    model_clear();
    #1 settled = 1'b1;
    repeat (5) @(posedge clk);
    #1 settled = 1'b0;
    clr_raw = 1'b0;
    repeat (10) @(posedge clk);
    #1 settled = 1'b1;
  endtask

  initial begin
    model_clear();
    #12;
    check("rst_nout", nout, 0);
    check("rst_curr", curr, 0);
    check("rst_p", p, 0);
    check("rst_error", error, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    settled = 1'b1;

    // 3-cycle glitch on inc must be rejected
    @(posedge clk); #1 btn_raw[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1 btn_raw = '0;
    repeat (12) @(posedge clk);
    #1;
    check("glitch_nout", nout, 0);
    check("glitch_p", p, 0);

    // decimal saturation
    set_mode(4'd1);
    repeat (10) press(4'b0010);
    check("dec_d0", nout[4:0], 9);
    check("dec_err", error, 1);
    check("dec_p", p, 1);

    // hex with cursor on digit 1
    set_mode(4'd2);
    press(4'b1000);
    repeat (15) press(4'b0010);
    check("hex_curr", curr, 1);
    check("hex_d1", nout[9:5], 15);
    check("hex_err", error, 0);

    // BCD carry 0099 -> 0100
    set_mode(4'd5);
    repeat (9) press(4'b0010);
    press(4'b1000);
    repeat (9) press(4'b0010);
    press(4'b0001);
    press(4'b0010);
    check("bcd_carry", nout, {5'd0, 5'd1, 5'd0, 5'd0});

    // BCD borrow below zero
    set_mode(4'd1);
    set_mode(4'd5);
    press(4'b0100);
    check("bcd_borrow_n", nout, 0);
    check("bcd_borrow_e", error, 1);
    press(4'b0010);

    // clear switch
    pulse_clr();
    check("clr_nout", nout, 0);
    check("clr_err", error, 0);
    check("clr_p", p, 0);

    // mode change 1 -> 3 clears
    set_mode(4'd1);
    press(4'b0010);
    press(4'b0010);
    press(4'b1000);
    set_mode(4'd3);
    check("mchg_nout", nout, 0);
    check("mchg_curr", curr, 0);
    check("mchg_p", p, 0);

    // out-of-range mode ignores presses, re-entry keeps state
    press(4'b0010);
    set_mode(4'd6);
    press(4'b0010);
    press(4'b0010);
    press(4'b1000);
    check("m6_nout", nout, 1);
    check("m6_curr", curr, 0);
    set_mode(4'd3);
    check("reent_nout", nout, 1);
    check("reent_p", p, 1);

    // left + inc together: only cursor moves
    press(4'b1010);
    check("sim_curr", curr, 1);
    check("sim_nout", nout, 1);
    press(4'b0001);
    press(4'b0001);
    check("wrap_curr", curr, 3);

    // octal saturation on digit 3
    repeat (8) press(4'b0010);
    check("oct_d3", nout[19:15], 7);
    check("oct_err", error, 1);

    settled = 1'b0;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule

// File: doc/input_editor.md
# input_editor

Front-end plus 4-digit editor for the board-level manager. Debounces the four push-buttons and the clear switch, then edits a 4-digit number with cursor, per-digit increment/decrement and overflow detection, under the mode code supplied by the manager FSM. Outputs feed the 7-segment formatter (`nout`, `curr`, `p`) and the manager's error override (`error`).

## Interface
- `DB_CYCLES`, default 1_000_000: consecutive stable samples a raw input needs before its debounced value changes (10 ms at 100 MHz).
- `clk` in 1: single system clock; all logic on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `btn_raw` in 4: raw buttons; [0]=right, [1]=inc, [2]=dec, [3]=left; active-high.
- `clr_raw` in 1: raw clear switch (switch[0]); active-high level.
- `mode` in 4: manager state code; editing enabled only for 1..5.
- `curr` out 3: cursor digit index 0..3 (0 = rightmost); bit 2 always 0.
- `nout` out 20: four 5-bit digit codes, digit3 in [19:15] … digit0 in [4:0]; codes 0..15 = hex value.
- `p` out 1: edited flag; 1 once any inc/dec has been applied since last clear/mode change.
- `error` out 1: sticky overflow/underflow flag.

## Operation
- Debounce, per input: 2-FF synchronizer, then counter that restarts on every change of the synchronized value. Debounced value updates when the sample has been stable `DB_CYCLES` cycles.
- Buttons: one-cycle pulse on each debounced 0→1 transition; release produces nothing.
- Clear switch: debounced level. While 1: digits = 0, `curr` = 0, `p` = 0, `error` = 0. Applies in any mode.
- Mode digit maximum: 1 = 9 (decimal), 2 = 15 (hex), 3 = 7 (octal), 4 = 1 (binary), 5 = decimal with carry.
- Modes 1–4, inc at cursor digit: below max, +1; at max, digit unchanged and `error` = 1.
- Modes 1–4, dec at cursor digit: above 0, −1; at 0, digit unchanged and `error` = 1.
- Mode 5: inc/dec add/subtract 10^curr to the whole 4-digit BCD value, with carry/borrow into higher digits.
  - A result above 9999 or below 0000 leaves the value unchanged and sets `error`.
- left: `curr` +1, wrapping 3→0. right: `curr` −1, wrapping 0→3. Cursor moves never set `error`.
- Any successful or saturated inc/dec sets `p` = 1.
- A `mode` change between two values both in 1..5 clears digits, `curr`, `p` and `error`, exactly as clear does.
- `mode` outside 1..5: all pulses ignored; registers hold. Entering 1..5 from outside does not clear.
- Simultaneous pulses: one action per cycle, priority clear > left > right > inc > dec; lower-priority pulses in that cycle are dropped.
- `error` remains 1 until clear or a qualifying mode change; further edits are still applied while it is 1.

## Timing
- Reset (`rst` = 0): synchronizers, debounce counters, debounced levels, digits, `curr`, `p`, `error` all 0, immediately and asynchronously.
- Raw edge to debounced change: 2 synchronizer cycles + `DB_CYCLES` cycles; glitches shorter than `DB_CYCLES` are rejected.
- Button pulse to register update: the next `clk` edge, so outputs change one cycle after the pulse.
- Clear level: effective on the same edge its debounced level is 1, and on every cycle it stays 1.
- All outputs are registered; no combinational path from inputs.

## Structure
- Shared package: mode codes (`MODE_DEC`=1, `MODE_HEX`=2, `MODE_OCT`=3, `MODE_BIN`=4, `MODE_BCD`=5), digit width 5, digit count 4, button index constants.
- Sub-module `debounce`: parameter `DB_CYCLES`, outputs `level` and `rise_pulse`. Instantiated 5 times (4 buttons, 1 switch).
- Editor datapath and cursor logic live in the top.

## Test plan
(`DB_CYCLES` = 4 in all scenarios.)
- Reset, then glitch: assert `rst`=0, then `btn_raw[1]` high for 3 cycles → `nout`=0, `curr`=0, `p`=0, `error`=0, no pulse.
- Mode 1 inc, cursor 0, 10 presses → digit0 ends at 9, `error`=1 after the 10th, `p`=1.
- Mode 2 cursor move: 1 left, then 15 inc → `curr`=1, `nout`[9:5]=15, `error`=0.
- Mode 5 carry: value 0099, cursor 0, one inc → `nout` digits 0,1,0,0.
- Mode 5 borrow: from 0000, one dec → value stays 0000, `error`=1.
- Clear and mode change:
  - Set `clr_raw` high → all cleared 6 cycles later; mode 1→3 change clears the same.
  - With mode 6, inc presses → no change.
  - left and inc in the same cycle → only `curr` changes.
